// File: rtl/uart_line_loader.sv
// Unpacks one framed UART packet per video line into a double-buffered pixel bus,
// validating framing, checksum, row range and inter-byte timeout, then ACK/NACKs.
module uart_line_loader #(
  parameter int         WIDTH          = 640,
  parameter int         HEIGHT         = 480,
  parameter int         BPP            = 3,
  parameter int         ROW_BITS       = 9,
  parameter logic [7:0] START_WORD     = 8'hAA,
  parameter logic [7:0] END_WORD       = 8'hDD,
  parameter logic [7:0] ACK_WORD       = 8'hFF,
  parameter logic [7:0] NACK_WORD      = 8'h11,
  parameter bit         CHECKSUM_EN    = 1'b1,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   tx_busy,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic [ROW_BITS-1:0]    row,
  output logic [WIDTH*BPP-1:0]   line_data,
  output logic                   line_valid,
  output logic                   frame_busy,
  output logic [7:0]             err_count
);

  // state     | meaning
  // S_IDLE    | waiting for START_WORD
  // S_ROW_HI  | expecting row high byte
  // S_ROW_LO  | expecting row low byte
  // S_PAYLOAD | collecting NBYTES of pixel data into the shadow line
  // S_CSUM    | expecting XOR checksum byte
  // S_END     | expecting END_WORD, final validation
  // S_RESP    | waiting for transmitter to send ACK/NACK

  localparam int          LBITS     = WIDTH * BPP;
  localparam int          NBYTES    = (LBITS + 7) / 8;
  localparam int          CW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HEIGHT_W  = 32'(HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_HI, S_ROW_LO, S_PAYLOAD, S_CSUM, S_END, S_RESP
  } state_t;

  state_t               state;
  logic [7:0]           row_hi;
  logic [7:0]           csum;
  logic [ROW_BITS-1:0]  row_sh;
  logic [LBITS-1:0]     line_sh;
  logic [CW-1:0]        byte_cnt;
  logic [31:0]          gap;
  logic                 err;
  logic                 row_oor;
  logic                 end_err;

  assign row_oor = (32'(row_sh) >= HEIGHT_W);
  assign end_err = err | row_oor | (rx_data != END_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row_hi     <= '0;
      csum       <= '0;
      row_sh     <= '0;
      line_sh    <= '0;
      byte_cnt   <= '0;
      gap        <= '0;
      err        <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      row        <= '0;
      line_data  <= '0;
      line_valid <= 1'b0;
      frame_busy <= 1'b0;
      err_count  <= '0;
    end else begin
      tx_start   <= 1'b0;
      line_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == START_WORD) begin
            state      <= S_ROW_HI;
            frame_busy <= 1'b1;
            err        <= 1'b0;
            gap        <= '0;
            csum       <= '0;
          end
        end
        S_RESP: begin
          if (!tx_busy) begin
            tx_data    <= err ? NACK_WORD : ACK_WORD;
            tx_start   <= 1'b1;
            frame_busy <= 1'b0;
            err        <= 1'b0;
            state      <= S_IDLE;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: begin
          if (rx_valid) begin
            gap <= '0;
            case (state)
              S_ROW_HI: begin
                row_hi <= rx_data;
                csum   <= csum ^ rx_data;
                state  <= S_ROW_LO;
              end
              S_ROW_LO: begin
                row_sh   <= ROW_BITS'({row_hi, rx_data});
                csum     <= csum ^ rx_data;
                byte_cnt <= '0;
                state    <= S_PAYLOAD;
              end
              S_PAYLOAD: begin
                // Bits of the last byte that fall past the line end have no home.
                for (int i = 0; i < LBITS; i++)
                  if (byte_cnt == CW'(i / 8)) line_sh[i] <= rx_data[i % 8];
                csum     <= csum ^ rx_data;
                byte_cnt <= byte_cnt + CW'(1);
                if (byte_cnt == LAST_BYTE) state <= CHECKSUM_EN ? S_CSUM : S_END;
              end
              S_CSUM: begin
                if (rx_data != csum) err <= 1'b1;
                state <= S_END;
              end
              S_END: begin
                err   <= end_err;
                state <= S_RESP;
                if (!end_err) begin
                  row        <= row_sh;
                  line_data  <= line_sh;
                  line_valid <= 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end else if (TO_LIMIT != 0 && gap == TO_LIMIT) begin
            err   <= 1'b1;
            state <= S_RESP;
          end else if (TO_LIMIT != 0) begin
            gap <= gap + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_loader.sv
// Randomized frame bench for uart_line_loader: a default-size instance with checksum
// and a short timeout, plus a narrow instance without checksum or timeout.
module tb_uart_line_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    rx_data0 = '0, rx_data1 = '0;
  logic          rx_valid0 = 1'b0, rx_valid1 = 1'b0;
  logic          tx_busy0 = 1'b0, tx_busy1 = 1'b0;
  logic [7:0]    tx_data0, tx_data1;
  logic          tx_start0, tx_start1;
  logic [8:0]    row0, row1;
  logic [1919:0] line_data0;
  logic [38:0]   line_data1;
  logic          line_valid0, line_valid1;
  logic          frame_busy0, frame_busy1;
  logic [7:0]    err_count0, err_count1;

  uart_line_loader #(.TIMEOUT_CYCLES(50)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_busy(tx_busy0), .tx_data(tx_data0), .tx_start(tx_start0), .row(row0),
    .line_data(line_data0), .line_valid(line_valid0), .frame_busy(frame_busy0),
    .err_count(err_count0));

  uart_line_loader #(.WIDTH(13), .CHECKSUM_EN(1'b0), .TIMEOUT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_busy(tx_busy1), .tx_data(tx_data1), .tx_start(tx_start1), .row(row1),
    .line_data(line_data1), .line_valid(line_valid1), .frame_busy(frame_busy1),
    .err_count(err_count1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_t = 0;
  int nresp0 = 0, nresp1 = 0, nlv0 = 0, nlv1 = 0;
  int resp_cyc0 = 0, resp_cyc1 = 0, lv_cyc0 = 0, lv_cyc1 = 0;
  logic [7:0] resp_data0 = '0, resp_data1 = '0;

  logic [7:0]    pay [240];
  logic [1919:0] model_line0 = '0;
  logic [38:0]   model_line1 = '0;
  logic [8:0]    model_row0 = '0, model_row1 = '0;
  logic [7:0]    model_err0 = '0, model_err1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start0)   begin nresp0++; resp_cyc0 = cyc; resp_data0 = tx_data0; end
    if (tx_start1)   begin nresp1++; resp_cyc1 = cyc; resp_data1 = tx_data1; end
    if (line_valid0) begin nlv0++; lv_cyc0 = cyc; end
    if (line_valid1) begin nlv1++; lv_cyc1 = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_line(input int sel);
    if (sel == 0) begin
      for (int c = 0; c < 30; c++)
        check($sformatf("line0[%0d]", c), line_data0[c*64 +: 64], model_line0[c*64 +: 64]);
    end else begin
      check("line1", 64'(line_data1), 64'(model_line1));
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] b);
    @(posedge clk); #1;
    if (sel == 0) begin rx_data0 = b; rx_valid0 = 1'b1; end
    else          begin rx_data1 = b; rx_valid1 = 1'b1; end
    last_t = cyc;
    @(posedge clk); #1;
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask

  task automatic sat_inc(inout logic [7:0] v);
    if (v != 8'hFF) v = v + 8'd1;
  endtask

  task automatic send_frame(input int sel, input logic [15:0] r, input logic csum_bad,
                            input logic [7:0] endb, input int busy_n);
    int n, t, rb, lb, got_cyc, got_lv_cyc;
    logic [7:0] x, got_data;
    logic ok;
    n = (sel == 0) ? 240 : 5;
    x = r[15:8] ^ r[7:0];
    drive(sel, 8'hAA);
    drive(sel, r[15:8]);
    check("busy_mid", (sel == 0) ? frame_busy0 : frame_busy1, 1);
    drive(sel, r[7:0]);
    for (int k = 0; k < n; k++) begin
      drive(sel, pay[k]);
      x = x ^ pay[k];
    end
    if (sel == 0) drive(sel, csum_bad ? ~x : x);
    rb = (sel == 0) ? nresp0 : nresp1;
    lb = (sel == 0) ? nlv0 : nlv1;
    drive(sel, endb);
    t = last_t;
    if (busy_n > 0) begin
      if (sel == 0) tx_busy0 = 1'b1; else tx_busy1 = 1'b1;
      repeat (busy_n) @(posedge clk);
      #1;
      tx_busy0 = 1'b0;
      tx_busy1 = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      if (((sel == 0) ? nresp0 : nresp1) != rb) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    ok = (endb == 8'hDD) && (r[8:0] < 9'd480) && !(sel == 0 && csum_bad);
    got_cyc    = (sel == 0) ? resp_cyc0 : resp_cyc1;
    got_lv_cyc = (sel == 0) ? lv_cyc0 : lv_cyc1;
    got_data   = (sel == 0) ? resp_data0 : resp_data1;
    check("resp_count", 64'(((sel == 0) ? nresp0 : nresp1) - rb), 1);
    check("resp_data", got_data, ok ? 8'hFF : 8'h11);
    check("resp_cycle", 64'(got_cyc - t), 64'(2 + busy_n));
    check("lv_count", 64'(((sel == 0) ? nlv0 : nlv1) - lb), ok ? 1 : 0);
    if (ok) begin
      check("lv_cycle", 64'(got_lv_cyc - t), 1);
      if (sel == 0) begin
        for (int k = 0; k < 240; k++) model_line0[k*8 +: 8] = pay[k];
        model_row0 = r[8:0];
      end else begin
        for (int i = 0; i < 39; i++) model_line1[i] = pay[i/8][i%8];
        model_row1 = r[8:0];
      end
    end else begin
      if (sel == 0) sat_inc(model_err0); else sat_inc(model_err1);
    end
    if (sel == 0) begin
      check("row0", row0, model_row0);
      check("err_count0", err_count0, model_err0);
      check("busy_after0", frame_busy0, 0);
    end else begin
      check("row1", row1, model_row1);
      check("err_count1", err_count1, model_err1);
      check("busy_after1", frame_busy1, 0);
    end
    check_line(sel);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 240; k++) pay[k] = 8'($urandom);
  endtask

  initial begin
    int rb, lb, t, d;
    logic [15:0] r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", row0, 0);
    check("rst_err", err_count0, 0);
    check("rst_txdata", tx_data0, 0);
    check("rst_busy", frame_busy0, 0);
    check("rst_lv", line_valid0, 0);
    check_line(0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 240; k++) pay[k] = 8'h00;
    send_frame(0, 16'h0105, 1'b0, 8'hDD, 0);
    check("row_261", row0, 9'd261);

    for (int k = 0; k < 240; k++) pay[k] = 8'(k);
    send_frame(0, 16'h0000, 1'b0, 8'hDD, 2);
    check("byte1", line_data0[15:8], 8'h01);
    check("byte239", line_data0[1919:1912], 8'hEF);

    fill_random();
    send_frame(0, 16'h0010, 1'b0, 8'h33, 0);
    check("err_after_bad_end", err_count0, 1);
    check("kept_byte239", line_data0[1919:1912], 8'hEF);

    fill_random();
    send_frame(0, 16'h01E0, 1'b0, 8'hDD, 1);

    fill_random();
    send_frame(0, 16'h0042, 1'b1, 8'hDD, 0);

    for (int f = 0; f < 6; f++) begin
      fill_random();
      r = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 520));
      send_frame(0, r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0) ? 8'h5A : 8'hDD,
                 $urandom_range(0, 4));
    end

    for (int f = 0; f < 6; f++) begin
      fill_random();
      r = 16'($urandom_range(0, 600));
      send_frame(1, r, 1'b1, ($urandom_range(0, 3) == 0) ? 8'hAA : 8'hDD, $urandom_range(0, 3));
    end

    // Stall after 100 payload bytes; the short-timeout instance must NACK.
    fill_random();
    rb = nresp0;
    lb = nlv0;
    drive(0, 8'hAA);
    drive(0, 8'h00);
    drive(0, 8'h07);
    for (int k = 0; k < 100; k++) drive(0, pay[k]);
    t = last_t;
    for (int i = 0; i < 100; i++) begin
      if (nresp0 != rb) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    d = resp_cyc0 - t;
    sat_inc(model_err0);
    check("to_count", 64'(nresp0 - rb), 1);
    check("to_data", resp_data0, 8'h11);
    check("to_not_early", 64'(d >= 50), 1);
    check("to_not_late", 64'(d <= 56), 1);
    check("to_no_lv", 64'(nlv0 - lb), 0);
    check("to_err", err_count0, model_err0);
    check_line(0);

    // Reset in the middle of a payload.
    fill_random();
    drive(0, 8'hAA);
    drive(0, 8'h00);
    drive(0, 8'h09);
    for (int k = 0; k < 50; k++) drive(0, pay[k]);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_line0 = '0; model_line1 = '0;
    model_row0 = '0;  model_row1 = '0;
    model_err0 = '0;  model_err1 = '0;
    check("mid_rst_row", row0, 0);
    check("mid_rst_err", err_count0, 0);
    check("mid_rst_txdata", tx_data0, 0);
    check("mid_rst_busy", frame_busy0, 0);
    check("mid_rst_txstart", tx_start0, 0);
    check("mid_rst_err1", err_count1, 0);
    check_line(0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    fill_random();
    send_frame(0, 16'h0123, 1'b0, 8'hDD, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_line_loader.md
# uart_line_loader

Receives one video line per framed packet from the UART byte stream and unpacks it into a WIDTH×BPP pixel bus with a row index. It validates framing, an optional XOR checksum, row range and inter-byte timeout, and answers each frame with an ACK or NACK byte through the UART transmitter. The block sits between `uart_receiver`/`uart_transmiter` and the VGA frame store. It double-buffers the line, so the output bus changes only on a fully validated frame.

## Interface
Parameters:
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: number of valid rows; a row ≥ HEIGHT is an error.
- `BPP`, 3: bits per pixel.
- `ROW_BITS`, 9: width of `row`.
- `START_WORD`, 8'hAA: frame start byte.
- `END_WORD`, 8'hDD: frame end byte.
- `ACK_WORD`, 8'hFF: success response.
- `NACK_WORD`, 8'h11: failure response.
- `CHECKSUM_EN`, 1: a checksum byte precedes END.
- `TIMEOUT_CYCLES`, 1_000_000: maximum inter-byte gap inside a frame; 0 disables the timeout.
- Derived `NBYTES` = ceil(WIDTH·BPP/8): 240 at defaults.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `tx_busy` in 1: the transmitter is sending.
- `tx_data` out 8: response byte, held stable after `tx_start`.
- `tx_start` out 1: one-cycle start strobe.
- `row` out ROW_BITS: row index of the last good line.
- `line_data` out WIDTH·BPP: last good line. Pixel p occupies bits [BPP·p+BPP-1 : BPP·p].
- `line_valid` out 1: one-cycle pulse when `row`/`line_data` update.
- `frame_busy` out 1: high while not in IDLE.
- `err_count` out 8: saturating count of NACKed frames.

## Operation
- States: IDLE, ROW_HI, ROW_LO, PAYLOAD, CSUM, END, RESP. Transitions are taken on an accepted byte (`rx_valid`=1) unless stated otherwise.
- IDLE: a byte equal to START_WORD goes to ROW_HI. Any other byte is ignored and is not counted.
- ROW_HI then ROW_LO: the row field is {hi, lo} truncated to ROW_BITS, held in a shadow register. Then go to PAYLOAD with byte counter = 0.
- PAYLOAD:
  - Byte k is written to shadow bits [8k+7:8k].
  - Bits beyond WIDTH·BPP in the last byte are discarded.
  - After byte NBYTES-1, go to CSUM if CHECKSUM_EN, else to END.
- CSUM: the received byte is compared with the running XOR of ROW_HI, ROW_LO and all payload bytes. A mismatch sets the error flag. Go to END.
- END:
  - Any byte other than END_WORD sets the error flag.
  - A shadow row ≥ HEIGHT sets the error flag.
  - Go to RESP.
  - If there is no error: copy the shadow row and line to `row`/`line_data` and pulse `line_valid`.
- Bytes carry no escaping. START_WORD inside the payload is plain data.
- Timeout:
  - In ROW_HI..END the gap counter clears on each accepted byte and increments otherwise.
  - Reaching TIMEOUT_CYCLES sets the error flag and forces RESP; `line_data` is untouched.
- RESP:
  - `rx_valid` is ignored.
  - When `tx_busy`=0: load `tx_data` = (error ? NACK_WORD : ACK_WORD), pulse `tx_start`, clear the error flag, and go to IDLE.
  - On error, `err_count` increments and saturates at 255.
- Reset (asynchronous, any state, including mid-frame): state=IDLE; `row`, `line_data`, `tx_data`, `err_count`, the shadows and the counters = 0; `tx_start`, `line_valid`, `frame_busy` = 0.

## Timing
- Outputs are registered; no combinational path from input to output.
- END byte strobed in cycle t:
  - `line_valid`=1 and the new `row`/`line_data` in cycle t+1.
  - `tx_start` in cycle t+2 if `tx_busy` was 0 in t+1. Otherwise the first cycle after `tx_busy` falls.
- Timeout fires in the cycle where the counter equals TIMEOUT_CYCLES. `tx_start` follows at least one cycle later.
- `frame_busy` rises the cycle after START is accepted and falls with the `tx_start` cycle.
- Back-to-back frames: a START arriving while in RESP is lost. The sender waits for ACK/NACK; this is the protocol contract.
- `line_data` stays stable between `line_valid` pulses, including across bad frames.

## Test plan
- Good frame (defaults): AA 01 05, 240×00, csum 04, DD. Expected: `row`=261, `line_data`=0, `line_valid` pulse, `tx_data`=FF, `err_count`=0.
- Payload byte k = k, row 0x0000, correct XOR. Expected: `line_data`[15:8]=01, [1919:1912]=EF, ACK.
- Bad end byte (DD replaced by 33). Expected: NACK 11, `line_data` unchanged from the previous good line, `err_count`=1.
- Row out of range (row 0x01E0=480) with a correct checksum. Expected: NACK, no `line_valid`.
- Bad checksum.
  - With CHECKSUM_EN=1: NACK.
  - With CHECKSUM_EN=0 and the checksum byte omitted: ACK.
- Stall and reset.
  - Stop after 100 payload bytes with TIMEOUT_CYCLES=50: NACK at gap cycle 50.
  - Separately, assert `rst_n` mid-payload: all outputs return to 0, and the next good frame returns ACK.
